// File: rtl/audio_avg_filter_pkg.sv
// Shared types and defaults for the stereo moving-average filter.
package audio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        ACC,
        WAIT,
        WR
    } state_t;

    localparam int unsigned DEFAULT_WIDTH      = 24;
    localparam int unsigned DEFAULT_LOG2_DEPTH = 3;

    // The running sum of 2^log2_depth samples needs log2_depth guard bits.
    function automatic int unsigned acc_width(input int unsigned width,
                                              input int unsigned log2_depth);
        return width + log2_depth;
    endfunction

endpackage

// File: rtl/audio_avg_filter_if.sv
// Codec read/write handshake between the filter (master) and the audio codec (slave).
interface audio_avg_filter_if #(
    parameter int unsigned WIDTH = audio_pkg::DEFAULT_WIDTH
);

    logic             bypass;
    logic             read_ready;
    logic [WIDTH-1:0] readdata_left;
    logic [WIDTH-1:0] readdata_right;
    logic             read;
    logic             write_ready;
    logic [WIDTH-1:0] writedata_left;
    logic [WIDTH-1:0] writedata_right;
    logic             write;

    modport master (
        input  bypass,
        input  read_ready,
        input  readdata_left,
        input  readdata_right,
        output read,
        input  write_ready,
        output writedata_left,
        output writedata_right,
        output write
    );

    modport slave (
        output bypass,
        output read_ready,
        output readdata_left,
        output readdata_right,
        input  read,
        output write_ready,
        input  writedata_left,
        input  writedata_right,
        input  write
    );

endinterface

// File: rtl/audio_avg_filter_avg_channel.sv
// One channel of the moving average: circular history buffer, write pointer and running sum.
module avg_channel
    import audio_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned LOG2_DEPTH = DEFAULT_LOG2_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    update,
    input  logic signed [WIDTH-1:0] sample_in,
    output logic signed [WIDTH-1:0] avg_out
);

    localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
    localparam int unsigned AW    = acc_width(WIDTH, LOG2_DEPTH);

    logic signed [WIDTH-1:0]      hist [DEPTH];
    logic        [LOG2_DEPTH-1:0] ptr;
    logic signed [AW-1:0]         acc;
    logic signed [AW-1:0]         acc_next;
    logic signed [AW-1:0]         new_ext;
    logic signed [AW-1:0]         old_ext;

    assign new_ext  = {{LOG2_DEPTH{sample_in[WIDTH-1]}}, sample_in};
    assign old_ext  = {{LOG2_DEPTH{hist[ptr][WIDTH-1]}}, hist[ptr]};
    assign acc_next = acc + new_ext - old_ext;

    // Average of the sum that includes the incoming sample, so the parent can
    // register it in the same cycle the history is updated. Taking the upper
    // WIDTH bits equals an arithmetic shift right by LOG2_DEPTH (floor).
    assign avg_out = acc_next[LOG2_DEPTH +: WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                hist[i] <= '0;
            end
        end else if (update) begin
            acc       <= acc_next;
            hist[ptr] <= sample_in;
            ptr       <= ptr + LOG2_DEPTH'(1);
        end
    end

endmodule

// File: rtl/audio_avg_filter.sv
// Stereo moving-average filter between the codec read and write ports, with raw bypass.
module audio_avg_filter
    import audio_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned LOG2_DEPTH = DEFAULT_LOG2_DEPTH
) (
    input logic                CLOCK_50,
    input logic                reset,
    audio_avg_filter_if.master codec
);

    state_t                  state;
    logic [WIDTH-1:0]        cap_left;
    logic [WIDTH-1:0]        cap_right;
    logic                    bypass_cap;
    logic                    update;
    logic signed [WIDTH-1:0] avg_left;
    logic signed [WIDTH-1:0] avg_right;

    assign update = (state == ACC);

    avg_channel #(
        .WIDTH      (WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_left (
        .clk       (CLOCK_50),
        .rst       (reset),
        .update    (update),
        .sample_in (cap_left),
        .avg_out   (avg_left)
    );

    avg_channel #(
        .WIDTH      (WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_right (
        .clk       (CLOCK_50),
        .rst       (reset),
        .update    (update),
        .sample_in (cap_right),
        .avg_out   (avg_right)
    );

    // read/write are set on entry to RD/WR and cleared on exit, so each is a
    // registered single-cycle pulse aligned with its state.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state                 <= IDLE;
            codec.read            <= 1'b0;
            codec.write           <= 1'b0;
            codec.writedata_left  <= '0;
            codec.writedata_right <= '0;
            cap_left              <= '0;
            cap_right             <= '0;
            bypass_cap            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (codec.read_ready) begin
                        state      <= RD;
                        codec.read <= 1'b1;
                    end
                end
                RD: begin
                    codec.read <= 1'b0;
                    cap_left   <= codec.readdata_left;
                    cap_right  <= codec.readdata_right;
                    bypass_cap <= codec.bypass;
                    state      <= ACC;
                end
                ACC: begin
                    codec.writedata_left  <= bypass_cap ? cap_left  : avg_left;
                    codec.writedata_right <= bypass_cap ? cap_right : avg_right;
                    state                 <= WAIT;
                end
                WAIT: begin
                    if (codec.write_ready) begin
                        state       <= WR;
                        codec.write <= 1'b1;
                    end
                end
                WR: begin
                    codec.write <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    codec.read  <= 1'b0;
                    codec.write <= 1'b0;
                end
            endcase
        end
    end

endmodule
